sdram_slot_arbiter: RTL and testbench

- Shares the single 16-bit SDRAM controller port between three requesters:
  - video fetch: 16-bit reads;
  - CPU: 8-bit read/write;
  - boot/ioctl loader: 8-bit writes.
- Grants one access per memory slot, aligned to the slot strobe.
- Sits between the motherboard/loader logic and the sdram block.
- Replaces the ad-hoc reset-muxing of boot vs CPU signals at top level.

---
 rtl/sdram_slot_arbiter_if.sv | 51 +++++
 rtl/sdram_slot_arbiter.sv | 154 +++++++++++++++
 tb/tb_sdram_slot_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_slot_arbiter_if.sv
// rtl/sdram_slot_arbiter_if.sv - requester and sdram-side signal bundle for the slot arbiter
interface sdram_slot_arbiter_if;
  logic        slot_ce;
  logic        vid_req;
  logic [22:0] vid_addr;
  logic [15:0] vid_dout;
  logic        vid_ack;
  logic        boot_req;
  logic [22:0] boot_addr;
  logic [7:0]  boot_din;
  logic        boot_ack;
  logic        cpu_req;
  logic        cpu_we;
  logic [22:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        mem_start;
  logic        mem_we;
  logic [22:0] mem_addr;
  logic [7:0]  mem_din;
  logic [15:0] mem_dout;
  logic        mem_valid;
  logic        busy;

  modport master (
    input  slot_ce,
    input  vid_req, vid_addr,
    output vid_dout, vid_ack,
    input  boot_req, boot_addr, boot_din,
    output boot_ack,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_ack,
    output mem_start, mem_we, mem_addr, mem_din,
    input  mem_dout, mem_valid,
    output busy
  );

  modport slave (
    output slot_ce,
    output vid_req, vid_addr,
    input  vid_dout, vid_ack,
    output boot_req, boot_addr, boot_din,
    input  boot_ack,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_ack,
    input  mem_start, mem_we, mem_addr, mem_din,
    output mem_dout, mem_valid,
    input  busy
  );
endinterface

// File: rtl/sdram_slot_arbiter.sv
// rtl/sdram_slot_arbiter.sv - one sdram access per slot shared by video, loader and CPU
module sdram_slot_arbiter #(
  parameter int STARVE_MAX = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk_sys,
  input  logic               reset,
  sdram_slot_arbiter_if.master bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {G_VID, G_BOOT, G_CPU} grant_t;

  state_t        state_q, state_d;
  grant_t        grant_q, grant_d, gsel;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          mem_start_q, mem_start_d;
  logic          mem_we_q, mem_we_d;
  logic [22:0]   mem_addr_q, mem_addr_d;
  logic [7:0]    mem_din_q, mem_din_d;
  logic [15:0]   vid_dout_q, vid_dout_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          vid_ack_q, vid_ack_d;
  logic          boot_ack_q, boot_ack_d;
  logic          cpu_ack_q, cpu_ack_d;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gsel        = G_VID;
    starve_d    = starve_q;
    cnt_d       = cnt_q;
    mem_start_d = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    vid_dout_d  = vid_dout_q;
    cpu_dout_d  = cpu_dout_q;
    vid_ack_d   = 1'b0;
    boot_ack_d  = 1'b0;
    cpu_ack_d   = 1'b0;

    if (!bus.cpu_req) starve_d = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.slot_ce && (bus.vid_req || bus.boot_req || bus.cpu_req)) begin
          if (bus.cpu_req && starve_q >= STARVE_LIM) gsel = G_CPU;
          else if (bus.vid_req)                      gsel = G_VID;
          else if (bus.boot_req)                     gsel = G_BOOT;
          else                                       gsel = G_CPU;

          state_d     = S_WAIT;
          grant_d     = gsel;
          cnt_d       = '0;
          mem_start_d = 1'b1;
          case (gsel)
            G_VID: begin
              mem_we_d   = 1'b0;
              mem_addr_d = bus.vid_addr & ~23'd1;
              mem_din_d  = 8'h00;
            end
            G_BOOT: begin
              mem_we_d   = 1'b1;
              mem_addr_d = bus.boot_addr;
              mem_din_d  = bus.boot_din;
            end
            default: begin
              mem_we_d   = bus.cpu_we;
              mem_addr_d = bus.cpu_addr;
              mem_din_d  = bus.cpu_din;
            end
          endcase

          // Only slots actually handed to someone else count as lost for the CPU
          if (gsel == G_CPU)
            starve_d = '0;
          else if (bus.cpu_req && starve_q != STARVE_LIM)
            starve_d = starve_q + 1'b1;
        end
      end
      default: begin
        if (bus.mem_valid || cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          case (grant_q)
            G_VID: begin
              vid_ack_d  = 1'b1;
              vid_dout_d = bus.mem_valid ? bus.mem_dout : 16'hFFFF;
            end
            G_BOOT: boot_ack_d = 1'b1;
            default: begin
              cpu_ack_d = 1'b1;
              if (!mem_we_q)
                cpu_dout_d = !bus.mem_valid ? 8'hFF :
                             (mem_addr_q[0] ? bus.mem_dout[15:8] : bus.mem_dout[7:0]);
            end
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= G_VID;
      starve_q    <= '0;
      cnt_q       <= '0;
      mem_start_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      vid_dout_q  <= 16'h0000;
      cpu_dout_q  <= 8'hFF;
      vid_ack_q   <= 1'b0;
      boot_ack_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      starve_q    <= starve_d;
      cnt_q       <= cnt_d;
      mem_start_q <= mem_start_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      vid_dout_q  <= vid_dout_d;
      cpu_dout_q  <= cpu_dout_d;
      vid_ack_q   <= vid_ack_d;
      boot_ack_q  <= boot_ack_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  assign bus.mem_start = mem_start_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.vid_dout  = vid_dout_q;
  assign bus.cpu_dout  = cpu_dout_q;
  assign bus.vid_ack   = vid_ack_q;
  assign bus.boot_ack  = boot_ack_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.busy      = (state_q == S_WAIT);

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// tb/tb_sdram_slot_arbiter.sv - directed self-checking bench for sdram_slot_arbiter
module tb_sdram_slot_arbiter;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [2:0] acks;

  sdram_slot_arbiter_if bus();

  sdram_slot_arbiter #(.STARVE_MAX(2), .TIMEOUT(15)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus.master)
  );

  always #5 clk_sys = ~clk_sys;

  assign acks = {bus.vid_ack, bus.boot_ack, bus.cpu_ack};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic slot();
    bus.slot_ce = 1'b1;
    tick();
    bus.slot_ce = 1'b0;
  endtask

  // From the mem_start cycle: valid after lat cycles, returns in the ack cycle
  task automatic complete(input int lat, input logic [15:0] d);
    repeat (lat) tick();
    bus.mem_dout  = d;
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0;
  endtask

  always @(negedge clk_sys)
    if (!reset && $countones(acks) > 1) check("ack_onehot", {29'd0, acks}, 32'd0);

  logic [22:0] exp_addr [3];
  logic        exp_we   [3];
  logic [7:0]  exp_din  [3];
  logic [2:0]  exp_ack  [3];
  logic [22:0] st_addr  [4];
  logic [2:0]  st_ack   [4];
  int bad;

  initial begin
    bus.slot_ce = 0; bus.vid_req = 0; bus.vid_addr = '0;
    bus.boot_req = 0; bus.boot_addr = '0; bus.boot_din = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.mem_dout = '0; bus.mem_valid = 0;
    tick(); tick();
    reset = 1'b0;

    check("rst_mem_start", bus.mem_start, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_acks", acks, 0);
    check("rst_cpu_dout", bus.cpu_dout, 32'hFF);
    check("rst_vid_dout", bus.vid_dout, 32'h0000);

    // Idle slots with nothing requested
    bad = 0;
    for (int s = 0; s < 3; s++) begin
      slot();
      for (int i = 0; i < 16; i++) begin
        if (bus.mem_start || bus.busy) bad++;
        tick();
      end
    end
    check("idle_no_start", bad, 0);
    check("idle_cpu_dout", bus.cpu_dout, 32'hFF);
    check("idle_vid_dout", bus.vid_dout, 32'h0000);

    // Single CPU read, high byte
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 23'h000123;
    slot();
    check("cpu_rd_start", bus.mem_start, 1);
    check("cpu_rd_addr", bus.mem_addr, 32'h000123);
    check("cpu_rd_we", bus.mem_we, 0);
    check("cpu_rd_busy", bus.busy, 1);
    tick();
    check("cpu_rd_start_1cyc", bus.mem_start, 0);
    complete(4, 16'hA55A);
    check("cpu_rd_ack", acks, 3'b001);
    check("cpu_rd_dout", bus.cpu_dout, 32'hA5);
    check("cpu_rd_idle", bus.busy, 0);
    bus.cpu_req = 0;
    tick();
    check("cpu_rd_ack_once", acks, 0);

    // All three request in the same slot
    bus.vid_req = 1; bus.vid_addr = 23'h000457;
    bus.boot_req = 1; bus.boot_addr = 23'h000001; bus.boot_din = 8'h11;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 23'h000124; bus.cpu_din = 8'h77;
    exp_addr[0] = 23'h000456; exp_we[0] = 0; exp_din[0] = 8'h00; exp_ack[0] = 3'b100;
    exp_addr[1] = 23'h000001; exp_we[1] = 1; exp_din[1] = 8'h11; exp_ack[1] = 3'b010;
    exp_addr[2] = 23'h000124; exp_we[2] = 1; exp_din[2] = 8'h77; exp_ack[2] = 3'b001;
    for (int s = 0; s < 3; s++) begin
      slot();
      check($sformatf("sim%0d_start", s), bus.mem_start, 1);
      check($sformatf("sim%0d_addr", s), bus.mem_addr, exp_addr[s]);
      check($sformatf("sim%0d_we", s), bus.mem_we, exp_we[s]);
      if (s > 0) check($sformatf("sim%0d_din", s), bus.mem_din, exp_din[s]);
      complete(2, 16'h1234);
      check($sformatf("sim%0d_ack", s), acks, exp_ack[s]);
      if (s == 0) bus.vid_req = 0;
      if (s == 1) bus.boot_req = 0;
      if (s == 2) bus.cpu_req = 0;
      tick();
      check($sformatf("sim%0d_ack_once", s), acks, 0);
    end
    check("sim_vid_dout", bus.vid_dout, 32'h1234);
    check("sim_cpu_dout_kept", bus.cpu_dout, 32'hA5);

    // CPU starvation under permanent video load
    bus.vid_req = 1; bus.vid_addr = 23'h000100;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 23'h000201;
    st_addr[0] = 23'h000100; st_ack[0] = 3'b100;
    st_addr[1] = 23'h000100; st_ack[1] = 3'b100;
    st_addr[2] = 23'h000201; st_ack[2] = 3'b001;
    st_addr[3] = 23'h000100; st_ack[3] = 3'b100;
    for (int s = 0; s < 4; s++) begin
      slot();
      check($sformatf("stv%0d_addr", s), bus.mem_addr, st_addr[s]);
      complete(1, 16'hBEEF);
      check($sformatf("stv%0d_ack", s), acks, st_ack[s]);
      if (s == 2) bus.cpu_req = 0;
      tick();
    end
    check("stv_cpu_dout", bus.cpu_dout, 32'hBE);
    bus.vid_req = 0;

    // Boot write timeout, then a late mem_valid
    bus.boot_req = 1; bus.boot_addr = 23'h1FF000; bus.boot_din = 8'h5C;
    slot();
    check("to_addr", bus.mem_addr, 32'h1FF000);
    check("to_we", bus.mem_we, 1);
    check("to_din", bus.mem_din, 32'h5C);
    bad = 0;
    for (int i = 1; i < 15; i++) begin
      tick();
      if (acks != 0 || !bus.busy) bad++;
    end
    check("to_wait_quiet", bad, 0);
    tick();
    check("to_boot_ack", acks, 3'b010);
    check("to_idle", bus.busy, 0);
    bus.boot_req = 0;
    bus.mem_valid = 1;
    tick();
    bus.mem_valid = 0;
    check("to_late_ack", acks, 0);
    check("to_late_start", bus.mem_start, 0);
    tick();
    check("to_late_busy", bus.busy, 0);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 23'h000010;
    slot();
    check("to_next_start", bus.mem_start, 1);
    check("to_next_addr", bus.mem_addr, 32'h000010);
    complete(3, 16'h00C3);
    check("to_next_ack", acks, 3'b001);
    check("to_next_dout", bus.cpu_dout, 32'hC3);
    bus.cpu_req = 0;
    tick();

    // Video read timeout returns all ones
    bus.vid_req = 1; bus.vid_addr = 23'h000222;
    slot();
    repeat (15) tick();
    check("vto_ack", acks, 3'b100);
    check("vto_dout", bus.vid_dout, 32'hFFFF);
    bus.vid_req = 0;
    tick();

    // Reset during a video read
    bus.vid_req = 1; bus.vid_addr = 23'h000300;
    slot();
    check("rm_busy", bus.busy, 1);
    tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    check("rm_busy_after", bus.busy, 0);
    check("rm_no_ack", acks, 0);
    bus.mem_dout = 16'hDEAD; bus.mem_valid = 1;
    tick();
    bus.mem_valid = 0;
    check("rm_late_ack", acks, 0);
    check("rm_vid_dout", bus.vid_dout, 32'h0000);
    tick();
    slot();
    check("rm_retry_start", bus.mem_start, 1);
    check("rm_retry_addr", bus.mem_addr, 32'h000300);
    complete(3, 16'h5678);
    check("rm_retry_ack", acks, 3'b100);
    check("rm_retry_dout", bus.vid_dout, 32'h5678);
    bus.vid_req = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
